// File: rtl/fifo_stream_reader_if.sv
// fifo_stream_reader_if
// Bundles the queue read port and the downstream valid/ready stream of the
// FIFO stream reader. The master modport is the reader itself; the slave
// modport is the environment (queue plus downstream consumer).
// BIT_WIDTH must be overridden to match the queue word width.

interface fifo_stream_reader_if #(
    parameter int BIT_WIDTH = -1
);

    // Queue side
    logic                 fifo_rd_en;
    logic [BIT_WIDTH-1:0] fifo_rd_data;
    logic                 fifo_empty;

    // Stream side
    logic                 out_valid;
    logic [BIT_WIDTH-1:0] out_data;
    logic                 out_ready;
    logic                 out_eol;
    logic [1:0]           out_level;

    modport master (
        output fifo_rd_en,
        input  fifo_rd_data,
        input  fifo_empty,
        output out_valid,
        output out_data,
        input  out_ready,
        output out_eol,
        output out_level
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_rd_data,
        output fifo_empty,
        input  out_valid,
        input  out_data,
        output out_ready,
        input  out_eol,
        input  out_level
    );

endinterface

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
// Read-side adapter for the single-clock FIFO queue. Issues reads against the
// queue's 1-cycle-latency read port and re-presents the words as a
// valid/ready stream through a 2-entry skid buffer, so downstream may drop
// out_ready on any cycle without loss or duplication, while still sustaining
// one word per clock when the queue has data and downstream is ready.
//
// Optional feature macro: FIFO_READER_EOL_EN
//   defined   : a column counter flags the last word of each LINE_WIDTH line
//               on out_eol.
//   undefined : out_eol is tied low and no counter exists.
//
// Reset n_rst is synchronous and active-low.

module fifo_stream_reader #(
    parameter int BIT_WIDTH  = -1,
    parameter int LINE_WIDTH = 640
) (
    input  logic                 clock,
    input  logic                 n_rst,
    fifo_stream_reader_if.master bus
);

    // Parameter sanity: the word width has no usable default and the line
    // length must cover at least one word.
    generate
        if (BIT_WIDTH < 1) begin : g_bad_width
            $error("fifo_stream_reader: BIT_WIDTH must be overridden with a value >= 1");
        end
        if (LINE_WIDTH < 1) begin : g_bad_line
            $error("fifo_stream_reader: LINE_WIDTH must be >= 1");
        end
    endgenerate

    // Skid buffer: r_e0 is the head (what the stream presents), r_e1 the
    // second slot. r_occ counts valid entries (0..2).
    logic [1:0]           r_occ;
    logic [BIT_WIDTH-1:0] r_e0;
    logic [BIT_WIDTH-1:0] r_e1;

    // A read was accepted last cycle, so fifo_rd_data carries a word now.
    logic                 r_inflight;

    logic                 w_pop;
    logic                 w_push;
    logic [2:0]           w_pending;
    logic                 w_rd_en;

    // The stream consumes the head this cycle.
    assign w_pop  = (r_occ != 2'd0) && bus.out_ready;

    // The word requested last cycle lands in the buffer this cycle.
    assign w_push = r_inflight;

    // Entries that will be held or arriving after this cycle if no new read
    // is issued. Issuing a read is safe only while this stays below 2, which
    // keeps occ + inflight within the buffer depth. The pop term makes
    // out_ready reach fifo_rd_en combinationally, which is what lets the
    // reader keep one read per cycle in steady state.
    assign w_pending = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};

    assign w_rd_en = n_rst && !bus.fifo_empty && (w_pending < 3'd2);

    assign bus.fifo_rd_en = w_rd_en;

    // Track which cycle the queue's read data is valid on.
    always_ff @(posedge clock) begin
        if (!n_rst) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
        end
    end

    // Skid buffer update. On a simultaneous push and pop the head advances
    // and the arriving word fills the slot that frees up. The head is only
    // overwritten when a new word actually becomes the head, so out_data
    // keeps its last value once the buffer drains to empty.
    always_ff @(posedge clock) begin
        if (!n_rst) begin
            r_occ <= 2'd0;
            r_e0  <= '0;
            r_e1  <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b11: begin
                    if (r_occ == 2'd2) begin
                        r_e0 <= r_e1;
                        r_e1 <= bus.fifo_rd_data;
                    end else begin
                        r_e0 <= bus.fifo_rd_data;
                    end
                end
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_e0 <= bus.fifo_rd_data;
                    end else begin
                        r_e1 <= bus.fifo_rd_data;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    if (r_occ == 2'd2) begin
                        r_e0 <= r_e1;
                    end
                    r_occ <= r_occ - 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.out_valid = (r_occ != 2'd0);
    assign bus.out_data  = r_e0;
    assign bus.out_level = r_occ;

`ifdef FIFO_READER_EOL_EN

    // Column counter width; a single-word line still needs one bit.
    localparam int               COL_W    = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_WIDTH - 1);

    logic [COL_W-1:0] r_col;

    // Count delivered words within the current line, wrapping at line end.
    always_ff @(posedge clock) begin
        if (!n_rst) begin
            r_col <= '0;
        end else if (w_pop) begin
            if (r_col == COL_LAST) begin
                r_col <= '0;
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    assign bus.out_eol = bus.out_valid && (r_col == COL_LAST);

`else

    assign bus.out_eol = 1'b0;

`endif

endmodule
